cgr_reader: RTL and testbench



---
 rtl/cgr_pkg.sv | 25 ++
 rtl/cgr_addr_decode.sv | 28 ++
 rtl/cgr_reader.sv | 151 +++++++++++++++
 tb/tb_cgr_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgr_pkg.sv
// Shared definitions for the CGR k-mer counter: coordinate sizing, symbol
// encoding used by both the writer and the reader, and the reader's states.
package cgr_pkg;

   localparam int DATA_LEN_DEF = 3;

   localparam logic [1:0] SYM_A = 2'b00;
   localparam logic [1:0] SYM_C = 2'b01;
   localparam logic [1:0] SYM_G = 2'b10;
   localparam logic [1:0] SYM_T = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      OUT,
      FIN
   } state_t;

   // Frequency-memory address: {1'b0, x, 1'b0, y}
   function automatic int addr_w(input int data_len);
      return 2 * data_len + 2;
   endfunction

endpackage

// File: rtl/cgr_addr_decode.sv
// Maps a linear cell index onto the frequency-memory address and the k-mer
// whose CGR coordinates land in that cell.
module cgr_addr_decode
   import cgr_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF
) (
   input  logic [2*DATA_LEN-1:0]       idx,
   output logic [addr_w(DATA_LEN)-1:0] rd_addr,
   output logic [2*DATA_LEN-1:0]       kmer
);

   logic [DATA_LEN-1:0] x;
   logic [DATA_LEN-1:0] y;

   assign x       = idx[2*DATA_LEN-1:DATA_LEN];
   assign y       = idx[DATA_LEN-1:0];
   assign rd_addr = {1'b0, x, 1'b0, y};

   // Bit i of each coordinate carries symbol i; x supplies the symbol MSB.
   always_comb begin
      kmer = '0;
      for (int i = 0; i < DATA_LEN; i++) begin
         kmer[2*i +: 2] = {x[i], y[i]};
      end
   end

endmodule

// File: rtl/cgr_reader.sv
// Scans the CGR frequency memory after a counting pass and streams one
// (k-mer, count) beat per cell over a valid/ready interface.
module cgr_reader
   import cgr_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int CNT_W    = 16,
   parameter int RD_LAT   = 1
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       start,
   input  logic                       skip_zero,
   input  logic                       BC_mode,
   output logic [addr_w(DATA_LEN)-1:0] rd_addr,
   output logic                       ren,
   input  logic [CNT_W-1:0]           rd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2*DATA_LEN-1:0]      out_kmer,
   output logic [CNT_W-1:0]           out_count,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
   output logic                       aborted
);

   localparam int             IW       = 2 * DATA_LEN;
   localparam logic [IW-1:0]  IDX_MAX  = '1;
   localparam int             LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LW-1:0]  LAT_LAST = LW'(RD_LAT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic [LW-1:0]   lat_cnt;
   logic [LW-1:0]   lat_cnt_nxt;
   logic            skip_q;
   logic            skip_nxt;
   logic            capture;
   logic            step;
   logic            abort;
   logic            is_last;
   logic [IW-1:0]   dec_kmer;

   // idx only moves when entering READ, so the decoded address naturally
   // holds between reads and returns to 0 on reset.
   cgr_addr_decode #(
      .DATA_LEN (DATA_LEN)
   ) u_dec (
      .idx     (idx),
      .rd_addr (rd_addr),
      .kmer    (dec_kmer)
   );

   assign is_last   = (idx == IDX_MAX);
   assign ren       = (state == READ);
   assign out_valid = (state == OUT);
   assign out_last  = out_valid && is_last;
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      lat_cnt_nxt = lat_cnt;
      skip_nxt    = skip_q;
      capture     = 1'b0;
      step        = 1'b0;
      abort       = 1'b0;

      case (state)
         IDLE: begin
            if (start && !BC_mode) begin
               state_nxt = READ;
               idx_nxt   = '0;
               skip_nxt  = skip_zero;
            end
         end
         READ: begin
            state_nxt   = WAIT;
            lat_cnt_nxt = '0;
         end
         WAIT: begin
            if (lat_cnt == LAT_LAST) begin
               capture = 1'b1;
               if (skip_q && (rd_data == '0)) begin
                  step = 1'b1;
               end else begin
                  state_nxt = OUT;
               end
            end else begin
               lat_cnt_nxt = lat_cnt + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               step = 1'b1;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // The max cell always ends the scan; idx never wraps.
      if (step) begin
         if (is_last) begin
            state_nxt = FIN;
         end else begin
            state_nxt = READ;
            idx_nxt   = idx + 1'b1;
         end
      end

      // The writer reclaiming the memory kills the scan, dropping any pending beat.
      if (busy && BC_mode) begin
         state_nxt = IDLE;
         idx_nxt   = idx;
         capture   = 1'b0;
         abort     = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         idx       <= '0;
         lat_cnt   <= '0;
         skip_q    <= 1'b0;
         out_kmer  <= '0;
         out_count <= '0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         lat_cnt   <= lat_cnt_nxt;
         skip_q    <= skip_nxt;
         aborted   <= abort;
         if (capture) begin
            out_kmer  <= dec_kmer;
            out_count <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_cgr_reader.sv
// Scoreboard bench for cgr_reader: directed scans against a behavioural
// memory with RD_LAT=1 and a second instance with RD_LAT=3.
module tb_cgr_reader;
   import cgr_pkg::*;

   localparam int NCELL = 64;

   typedef struct packed {
      logic [7:0]  addr;
      logic [5:0]  kmer;
      logic [15:0] cnt;
      logic        last;
   } beat_t;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST_N, start, skip_zero, BC_mode, out_ready;
   logic [7:0]  rd_addr;
   logic        ren;
   logic [15:0] rd_data;
   logic        out_valid;
   logic [5:0]  out_kmer;
   logic [15:0] out_count;
   logic        out_last, busy, done, aborted;

   logic        start3;
   logic [7:0]  rd_addr3;
   logic        ren3;
   logic [15:0] rd_data3;
   logic        out_valid3;
   logic [5:0]  out_kmer3;
   logic [15:0] out_count3;
   logic        out_last3, busy3, done3, aborted3;

   cgr_reader #(.DATA_LEN(3), .CNT_W(16), .RD_LAT(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .skip_zero(skip_zero), .BC_mode(BC_mode),
      .rd_addr(rd_addr), .ren(ren), .rd_data(rd_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_kmer(out_kmer), .out_count(out_count),
      .out_last(out_last), .busy(busy), .done(done), .aborted(aborted)
   );

   cgr_reader #(.DATA_LEN(3), .CNT_W(16), .RD_LAT(3)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .start(start3), .skip_zero(1'b0), .BC_mode(BC_mode),
      .rd_addr(rd_addr3), .ren(ren3), .rd_data(rd_data3), .out_valid(out_valid3),
      .out_ready(1'b1), .out_kmer(out_kmer3), .out_count(out_count3),
      .out_last(out_last3), .busy(busy3), .done(done3), .aborted(aborted3)
   );

   // Memory returns real data only RD_LAT cycles after ren, garbage otherwise.
   logic [15:0] mem [NCELL];
   logic [15:0] pipe1;
   logic [15:0] pipe3 [3];
   always @(posedge CLK) pipe1 <= ren ? mem[{rd_addr[6:4], rd_addr[2:0]}] : 16'hDEAD;
   always @(posedge CLK) begin
      pipe3[0] <= ren3 ? mem[{rd_addr3[6:4], rd_addr3[2:0]}] : 16'hBEEF;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign rd_data  = pipe1;
   assign rd_data3 = pipe3[2];

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    n_beats = 0;
   int    n_done  = 0;
   int    n_abort = 0;
   int    n_ren   = 0;
   beat_t q[$];
   bit    hold_v  = 1'b0;
   logic [30:0] held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic beat_t model(input int i, input logic [15:0] c);
      beat_t      b;
      logic [5:0] v;
      v      = 6'(i);
      b.addr = {1'b0, v[5:3], 1'b0, v[2:0]};
      for (int s = 0; s < 3; s++) b.kmer[2*s +: 2] = {v[3+s], v[s]};
      b.cnt  = c;
      b.last = (i == NCELL - 1);
      return b;
   endfunction

   // Cells 0, 42 and 63 use hand-derived values; the rest come from the model.
   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (i == 0)       q.push_back('{8'h00, 6'h00, 16'd1, 1'b0});
         else if (i == 42) q.push_back('{8'h52, 6'b10_01_10, 16'd43, 1'b0});
         else if (i == 63) q.push_back('{8'h77, 6'h3F, 16'd64, 1'b1});
         else              q.push_back(model(i, 16'(i + 1)));
      end
   endtask

   task automatic fill_inc();
      for (int i = 0; i < NCELL; i++) mem[i] = 16'(i + 1);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start(input logic sz, output int at_cyc);
      at_cyc    = cyc;
      skip_zero = sz;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit which, output int at_cyc);
      at_cyc = -1;
      for (int k = 0; k < limit; k++) begin
         @(negedge CLK);
         if (which ? done3 : done) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: no done within %0d cycles", limit);
      end
      @(posedge CLK); #1;
   endtask

   task automatic wait_beats(input int target);
      int k = 0;
      while (n_beats < target && k < 500) begin
         @(negedge CLK); #1;
         k++;
      end
      if (n_beats < target) begin
         n_tests++; n_fail++;
         $display("FAIL beat_timeout: got %0d beats, required %0d", n_beats, target);
      end
      @(posedge CLK); #1;
   endtask

   task automatic wait_valid(input int limit);
      bit seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge CLK);
         seen = out_valid;
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL valid_timeout: out_valid not seen within %0d cycles", limit);
      end
      @(posedge CLK); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_addr"},   rd_addr,   0);
      check({tag, "_ren"},       ren,       0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_kmer"},  out_kmer,  0);
      check({tag, "_out_count"}, out_count, 0);
      check({tag, "_out_last"},  out_last,  0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
      check({tag, "_aborted"},   aborted,   0);
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Monitor: pops the scoreboard on every handshake and checks hold stability.
   initial forever begin
      @(negedge CLK);
      if (ren)     n_ren++;
      if (done)    n_done++;
      if (aborted) n_abort++;
      if (hold_v && out_valid)
         check("hold_stable", {1'b0, rd_addr, out_kmer, out_count, out_last}, {1'b0, held});
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got kmer 0x%0h count %0d, required no beat", out_kmer, out_count);
         end else begin
            check("beat_addr",  rd_addr,   q[0].addr);
            check("beat_kmer",  out_kmer,  q[0].kmer);
            check("beat_count", out_count, q[0].cnt);
            check("beat_last",  out_last,  q[0].last);
            void'(q.pop_front());
         end
         n_beats++;
      end
      hold_v = out_valid && !out_ready;
      held   = {rd_addr, out_kmer, out_count, out_last};
   end

   int    e3        = 0;
   int    ren3_cyc  = -1;
   bit    lat3_done = 1'b0;
   beat_t b3;

   initial forever begin
      @(negedge CLK);
      if (ren3 && ren3_cyc < 0) ren3_cyc = cyc;
      if (out_valid3) begin
         if (!lat3_done) begin
            check("lat3_ren_to_valid", cyc - ren3_cyc, 4);
            lat3_done = 1'b1;
         end
         b3 = model(e3, 16'(e3 + 1));
         check("lat3_addr",  rd_addr3,   b3.addr);
         check("lat3_kmer",  out_kmer3,  b3.kmer);
         check("lat3_count", out_count3, b3.cnt);
         check("lat3_last",  out_last3,  b3.last);
         e3++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, dc, b0, d0, a0, r0;
      bit got;
      RST_N = 1'b0; start = 1'b0; skip_zero = 1'b0; BC_mode = 1'b0;
      out_ready = 1'b1; start3 = 1'b0;
      fill_inc();
      tick(3);
      check_idle_outputs("reset");
      RST_N = 1'b1;
      tick();

      // Full scan, count = idx+1, ready held high
      push_range(0, 63);
      b0 = n_beats; d0 = n_done;
      pulse_start(1'b0, s);
      wait_done(400, 1'b0, dc);
      check("full_done_cycle", dc - s, 193);
      check("full_beats", n_beats - b0, 64);
      check("full_queue_empty", q.size(), 0);
      check("full_done_count", n_done - d0, 1);

      // Only cell 5 non-zero, skip_zero set
      for (int i = 0; i < NCELL; i++) mem[i] = 16'd0;
      mem[5] = 16'd9;
      q.push_back('{8'h05, 6'b01_00_01, 16'd9, 1'b0});
      b0 = n_beats; r0 = n_ren;
      pulse_start(1'b1, s);
      wait_done(400, 1'b0, dc);
      check("skip_done_cycle", dc - s, 130);
      check("skip_beats", n_beats - b0, 1);
      check("skip_ren_count", n_ren - r0, 64);
      check("skip_queue_empty", q.size(), 0);

      // Random backpressure with a stray start mid-scan
      fill_inc();
      push_range(0, 63);
      b0 = n_beats; d0 = n_done;
      pulse_start(1'b0, s);
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         out_ready = 1'($urandom_range(0, 1));
         start     = (k == 40);
         @(negedge CLK);
         if (done) got = 1'b1;
         @(posedge CLK); #1;
      end
      start = 1'b0; out_ready = 1'b1;
      check("rand_done_seen", got, 1);
      check("rand_beats", n_beats - b0, 64);
      check("rand_queue_empty", q.size(), 0);
      check("rand_done_count", n_done - d0, 1);

      // Abort while beat 10 is pending
      push_range(0, 9);
      b0 = n_beats; d0 = n_done; a0 = n_abort;
      pulse_start(1'b0, s);
      wait_beats(b0 + 10);
      out_ready = 1'b0;
      wait_valid(20);
      check("abort_pending_count", out_count, 11);
      BC_mode = 1'b1;
      tick();
      check("abort_pulse", aborted, 1);
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_ren", ren, 0);
      check("abort_no_done", done, 0);
      BC_mode = 1'b0;
      tick();
      check("abort_pulse_end", aborted, 0);
      BC_mode = 1'b1;
      pulse_start(1'b0, s);
      check("start_during_bc_ignored", busy, 0);
      BC_mode = 1'b0;
      tick(2);
      check("abort_beats", n_beats - b0, 10);
      check("abort_count", n_abort - a0, 1);
      check("abort_done_count", n_done - d0, 0);
      check("abort_queue_empty", q.size(), 0);

      out_ready = 1'b1;
      push_range(0, 63);
      b0 = n_beats;
      pulse_start(1'b0, s);
      wait_done(400, 1'b0, dc);
      check("rescan_beats", n_beats - b0, 64);
      check("rescan_queue_empty", q.size(), 0);

      // Reset mid-scan with a re-pulsed start while busy
      push_range(0, 4);
      b0 = n_beats;
      pulse_start(1'b0, s);
      wait_beats(b0 + 5);
      out_ready = 1'b0;
      wait_valid(20);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_ignored_valid", out_valid, 1);
      check("restart_ignored_count", out_count, 6);
      check("restart_ignored_kmer", out_kmer, 6'b01_00_01);
      d0 = n_done; a0 = n_abort;
      RST_N = 1'b0;
      tick();
      check_idle_outputs("midrst");
      RST_N = 1'b1;
      out_ready = 1'b1;
      tick(3);
      check("midrst_no_done", n_done - d0, 0);
      check("midrst_no_abort", n_abort - a0, 0);
      check("midrst_queue_empty", q.size(), 0);

      // RD_LAT=3 instance: full scan at 5 cycles per cell
      fill_inc();
      s = cyc;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_done(800, 1'b1, dc);
      check("lat3_done_cycle", dc - s, 321);
      check("lat3_beats", e3, 64);
      check("lat3_busy_after", busy3, 0);
      check("lat3_no_abort", aborted3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
